capture_readout: RTL and testbench
==================================

Name: capture_readout

Overview:
- Reads a completed capture back out of the sample RAM that the logic-capture engine filled, and streams it to the host-link transmitter (UART/USB byte path) over a valid/ready interface.
- Walks the circular buffer from the oldest pre-trigger sample (startAddr) for sampleCount samples, wrapping at DEPTH.
- Sits between the capture RAM read port and the host transmitter. Started by a control-register bit once the capture engine reports done.

Parameters:
- ADDR_W, 18, RAM address width.
- DEPTH, 262144, number of sample locations in the ring (≤ 2^ADDR_W). Addresses wrap from DEPTH-1 to 0.
- DATA_W, 8, sample width (one bit per probe channel).
- RAM_LAT, 1, RAM read latency in cycles, from ramEn to ramData valid (≥ 1).

Ports:
- clk  in  1  system clock. Single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a readout. Ignored while busy=1.
- abort  in  1  level; cancels an in-progress readout.
- startAddr  in  ADDR_W  address of the first (oldest) sample. Sampled on an accepted start.
- sampleCount  in  ADDR_W+1  number of samples to send. Sampled on an accepted start.
- ramEn  out  1  RAM read enable.
- ramAddress  out  ADDR_W  RAM read address.
- ramData  in  DATA_W  RAM read data. Valid RAM_LAT cycles after ramEn.
- outData  out  DATA_W  sample to the transmitter.
- outValid  out  1  outData valid.
- outReady  in  1  transmitter accepts outData this cycle.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse when the last sample has been accepted, or on abort.
- sentCount  out  ADDR_W+1  samples accepted so far in the current or last readout.

Behaviour:
- Reset values (asynchronous):
  - ramEn=0, ramAddress=0, outData=0, outValid=0, busy=0, done=0, sentCount=0.
  - FSM in IDLE; internal address and remaining count cleared.
- Reset asserted mid-readout: all of the above take effect immediately, with no partial done pulse.
- FSM states: IDLE, FETCH, WAIT, PRESENT, FINISH.
- IDLE:
  - On start=1, latch addr=startAddr and remaining=sampleCount, clear sentCount, set busy=1.
  - Next state: FETCH if sampleCount≠0, else FINISH.
- FETCH (1 cycle):
  - ramEn=1 and ramAddress=addr.
  - Next state: WAIT.
- WAIT (RAM_LAT cycles, counted by a down-counter):
  - ramEn=0.
  - On the final WAIT cycle, register ramData into outData and set outValid=1 for the next cycle.
  - Next state: PRESENT.
- PRESENT:
  - Hold outValid=1 and outData stable until outReady=1. outData never changes while outValid=1 and outReady=0.
  - On handshake:
    - outValid=0, sentCount+1, remaining-1.
    - addr = (addr==DEPTH-1) ? 0 : addr+1.
    - Next state: FETCH if remaining-1≠0, else FINISH.
- FINISH (1 cycle):
  - done=1 and busy=0 in the same cycle. Next state: IDLE.
  - busy asserts the cycle after an accepted start and stays high until FINISH.
- Throughput with outReady held high: one sample per RAM_LAT+2 cycles. For RAM_LAT=1, a sample is presented on cycles 3, 6, 9, … after start.
- Latency from accepted start to first outValid=1: RAM_LAT+2 cycles.
- Wrap: the address sequence is startAddr, startAddr+1, …, DEPTH-1, 0, 1, …
- sampleCount > DEPTH: the sequence keeps wrapping; no clamping.
- Abort:
  - abort=1 in any non-IDLE state forces the next state to FINISH.
  - ramEn=0 and outValid=0 on the next cycle.
  - sentCount holds samples accepted before the abort. A handshake in the same cycle as abort still counts.
  - abort in IDLE has no effect.
- start while busy=1 is ignored; startAddr and sampleCount may change freely while busy.
- start and abort in the same IDLE cycle: start wins, abort is ignored.
- Arithmetic: the address increment is modulo DEPTH. remaining and sentCount are ADDR_W+1 bits unsigned and never underflow.

Test Plan:
- Basic readout (bench with DEPTH=16, RAM_LAT=1, RAM[i]=i+8'h10, outReady=1):
  - Stimulus: start with startAddr=3, sampleCount=5.
  - Required: outData sequence 13,14,15,16,17; first outValid 3 cycles after start; ramAddress 3..7; a single done pulse; sentCount=5.
- Wrap:
  - Stimulus: startAddr=14, sampleCount=4.
  - Required: ramAddress 14,15,0,1; outData 1E,1F,10,11.
- Backpressure:
  - Stimulus: outReady low for 7 cycles on the 2nd sample.
  - Required: outData=14 held stable with outValid=1 throughout; no extra ramEn pulses; the sequence completes unchanged.
- Zero count:
  - Stimulus: sampleCount=0.
  - Required: no ramEn, no outValid; done pulses 2 cycles after start; sentCount=0.
- Abort and restart:
  - Stimulus: abort asserted after 2 samples accepted, then a new start while busy and a new start after done.
  - Required: done within 2 cycles of abort; sentCount=2; the start during busy is ignored; the restart runs normally.
- Reset mid-operation:
  - Stimulus: resetn low during PRESENT.
  - Required: outValid, busy and ramEn drop asynchronously; no done pulse; start after release works from IDLE.

Source files
------------

// File: rtl/capture_readout_if.sv
`default_nettype none
// ============================================================================
// capture_readout_if : capture RAM read port plus host-link byte stream
// Revision: 1.0
// ============================================================================
interface capture_readout_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8
);
   logic              ramEn;
   logic [ADDR_W-1:0] ramAddress;
   logic [DATA_W-1:0] ramData;
   logic [DATA_W-1:0] outData;
   logic              outValid;
   logic              outReady;

   modport master (
      output ramEn, ramAddress, outData, outValid,
      input  ramData, outReady
   );

   modport slave (
      input  ramEn, ramAddress, outData, outValid,
      output ramData, outReady
   );
endinterface
`default_nettype wire

// File: rtl/capture_readout.sv
`default_nettype none
// ============================================================================
// capture_readout : streams a finished capture out of the ring-buffer RAM
// Revision: 1.0
// ============================================================================
module capture_readout #(
   parameter int ADDR_W  = 18,
   parameter int DEPTH   = 262144,
   parameter int DATA_W  = 8,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] startAddr,
   input  logic [ADDR_W:0]   sampleCount,
   capture_readout_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sentCount
);
   localparam int                     c_WAIT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
   localparam logic [c_WAIT_W-1:0]    c_WAIT_LOAD = c_WAIT_W'(RAM_LAT - 1);
   localparam logic [ADDR_W-1:0]      c_LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_remaining;
   logic [c_WAIT_W-1:0] r_wait;
   logic                r_ram_en;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_valid;
   logic                r_busy;
   logic                r_done;
   logic [ADDR_W:0]     r_sent;

   logic [ADDR_W-1:0]   w_next_addr;
   logic [ADDR_W:0]     w_rem_dec;

   assign w_next_addr = (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;
   assign w_rem_dec   = (r_remaining != '0) ? r_remaining - 1'b1 : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_wait      <= '0;
         r_ram_en    <= 1'b0;
         r_ram_addr  <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sent      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr      <= startAddr;
                  r_remaining <= sampleCount;
                  r_sent      <= '0;
                  r_busy      <= 1'b1;
                  if (sampleCount != '0) begin
                     r_state    <= S_FETCH;
                     r_ram_en   <= 1'b1;
                     r_ram_addr <= startAddr;
                  end else begin
                     r_state <= S_FINISH;
                  end
               end
            end
            S_FETCH: begin
               r_ram_en <= 1'b0;
               r_wait   <= c_WAIT_LOAD;
               r_state  <= abort ? S_FINISH : S_WAIT;
            end
            S_WAIT: begin
               if (abort) begin
                  r_state <= S_FINISH;
               end else if (r_wait == '0) begin
                  r_out_data  <= bus.ramData;
                  r_out_valid <= 1'b1;
                  r_state     <= S_PRESENT;
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            S_PRESENT: begin
               // A handshake coinciding with abort is still counted.
               if (bus.outReady) begin
                  r_out_valid <= 1'b0;
                  r_sent      <= r_sent + 1'b1;
                  r_remaining <= w_rem_dec;
                  r_addr      <= w_next_addr;
               end
               if (abort) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_FINISH;
               end else if (bus.outReady) begin
                  if (w_rem_dec != '0) begin
                     r_state    <= S_FETCH;
                     r_ram_en   <= 1'b1;
                     r_ram_addr <= w_next_addr;
                  end else begin
                     r_state <= S_FINISH;
                  end
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ramEn      = r_ram_en;
   assign bus.ramAddress = r_ram_addr;
   assign bus.outData    = r_out_data;
   assign bus.outValid   = r_out_valid;
   assign busy           = r_busy;
   assign done           = r_done;
   assign sentCount      = r_sent;
endmodule
`default_nettype wire

// File: tb/tb_capture_readout.sv
`default_nettype none
// ============================================================================
// tb_capture_readout : randomized readout runs checked against a ring model
// Revision: 1.0
// ============================================================================
module tb_capture_readout;
   localparam int ADDR_W  = 5;
   localparam int DEPTH   = 16;
   localparam int DATA_W  = 8;
   localparam int RAM_LAT = 1;

   logic              clk = 1'b0;
   logic              resetn;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] startAddr;
   logic [ADDR_W:0]   sampleCount;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   sentCount;

   int n_total = 0;
   int n_bad   = 0;

   capture_readout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   capture_readout #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .RAM_LAT(RAM_LAT)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .abort      (abort),
      .startAddr  (startAddr),
      .sampleCount(sampleCount),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .sentCount  (sentCount)
   );

   always #5 clk = ~clk;

   // Sample RAM: RAM[i] = i + 0x10, one cycle read latency
   always @(posedge clk) begin
      if (bus.ramEn) bus.ramData <= {3'b000, bus.ramAddress} + 8'h10;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ring_addr(int sa, int k);
      return (sa + k) % DEPTH;
   endfunction

   // rdy_mode: 0 always ready, 1 stall stall_len cycles on sample stall_idx, 2 random
   task automatic readout(input int sa, input int cnt, input int rdy_mode,
                          input int stall_idx, input int stall_len,
                          input int abort_after, input int abort_dly,
                          input int busy_start_t, input bit abort_at_start);
      int t = 0, nfetch = 0, nacc = 0, t_ref = 0, t_hs = 0, t_abort = -1;
      int stall_cnt = 0, dly_cnt = 0;
      bit prev_pend = 0, finished = 0, aborted = 0, r;
      logic [DATA_W-1:0] ed;
      @(negedge clk);
      start = 1'b1; abort = abort_at_start;
      startAddr = ADDR_W'(sa); sampleCount = (ADDR_W+1)'(cnt);
      while (!finished && t < 400) begin
         @(negedge clk);
         t++;
         start = 1'b0; abort = 1'b0;
         startAddr = ADDR_W'($urandom); sampleCount = (ADDR_W+1)'($urandom);
         if (done) begin
            check("done_time", t, t_ref + 2);
            check("sent_count", sentCount, nacc);
            check("busy_at_done", busy, 0);
            finished = 1;
         end else begin
            check("busy", busy, 1);
            if (aborted && t == t_abort + 1) begin
               check("abort_ram_en", bus.ramEn, 0);
               check("abort_valid", bus.outValid, 0);
            end
            if (bus.ramEn) begin
               check("ram_addr", bus.ramAddress, ring_addr(sa, nfetch));
               check("fetch_order", nfetch, nacc);
               check("fetch_needed", nfetch < cnt, 1);
               nfetch++;
            end
            if (bus.outValid) begin
               if (!prev_pend) check("present_time", t, (nacc == 0) ? 3 : t_hs + 3);
               ed = 8'(ring_addr(sa, nacc) + 16);
               check("out_data", bus.outData, ed);
               check("sample_needed", nacc < cnt, 1);
            end
            case (rdy_mode)
               1: begin
                  r = !(bus.outValid && nacc == stall_idx && stall_cnt < stall_len);
                  if (bus.outValid && nacc == stall_idx) stall_cnt++;
               end
               2:       r = $urandom_range(0, 1) == 1;
               default: r = 1'b1;
            endcase
            bus.outReady = r;
            if (!aborted && abort_after >= 0 && nacc == abort_after) begin
               if (dly_cnt == abort_dly) begin
                  abort = 1'b1; aborted = 1; t_abort = t; t_ref = t;
               end
               dly_cnt++;
            end
            if (bus.outValid && r) begin
               nacc++; t_hs = t; t_ref = t;
            end
            prev_pend = bus.outValid && !r;
            if (t == busy_start_t) start = 1'b1;
         end
      end
      if (!finished) check("done_timeout", 0, 1);
      start = 1'b0; abort = 1'b0; bus.outReady = 1'b1;
      @(negedge clk);
      check("done_pulse_width", done, 0);
      check("idle_busy", busy, 0);
   endtask

   task automatic reset_mid();
      bit seen = 0;
      @(negedge clk);
      start = 1'b1; startAddr = 5'd2; sampleCount = 6'd6; bus.outReady = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         start = 1'b0;
         seen = bus.outValid;
      end
      check("reset_reached_present", seen, 1);
      #2 resetn = 1'b0;
      #1;
      check("rst_valid", bus.outValid, 0);
      check("rst_busy", busy, 0);
      check("rst_ram_en", bus.ramEn, 0);
      check("rst_sent", sentCount, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", done, 0);
      end
      resetn = 1'b1; bus.outReady = 1'b1;
   endtask

   initial begin
      int sa, cnt, ab;
      resetn = 1'b0; start = 1'b0; abort = 1'b0;
      startAddr = '0; sampleCount = '0; bus.outReady = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_ram_en", bus.ramEn, 0);
      check("reset_ram_addr", bus.ramAddress, 0);
      check("reset_out_data", bus.outData, 0);
      check("reset_valid", bus.outValid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sent", sentCount, 0);
      resetn = 1'b1;
      @(negedge clk);

      readout(3, 5, 0, -1, 0, -1, 0, -1, 0);    // basic
      readout(14, 4, 0, -1, 0, -1, 0, -1, 0);   // wrap
      readout(3, 5, 1, 1, 7, -1, 0, -1, 0);     // backpressure on 2nd sample
      readout(5, 0, 0, -1, 0, -1, 0, -1, 0);    // zero count
      readout(6, 8, 0, -1, 0, 2, 0, 4, 0);      // abort after 2, start while busy
      readout(9, 3, 0, -1, 0, -1, 0, -1, 0);    // restart after abort
      readout(12, 2, 0, -1, 0, -1, 0, -1, 1);   // start and abort together
      readout(15, 20, 0, -1, 0, -1, 0, 7, 0);   // longer than the ring
      reset_mid();
      readout(0, 3, 0, -1, 0, -1, 0, -1, 0);

      for (int i = 0; i < 12; i++) begin
         sa  = $urandom_range(0, DEPTH - 1);
         cnt = $urandom_range(0, 20);
         ab  = (cnt > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, cnt - 1) : -1;
         readout(sa, cnt, 2, -1, 0, ab, $urandom_range(0, 4),
                 $urandom_range(1, 10), $urandom_range(0, 3) == 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
